// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART interrupt-source logic
package uart_pkg;

    localparam logic [6:0] TRIG16_1  = 7'd1;
    localparam logic [6:0] TRIG16_4  = 7'd4;
    localparam logic [6:0] TRIG16_8  = 7'd8;
    localparam logic [6:0] TRIG16_14 = 7'd14;

    localparam logic [6:0] TRIG64_1  = 7'd1;
    localparam logic [6:0] TRIG64_16 = 7'd16;
    localparam logic [6:0] TRIG64_32 = 7'd32;
    localparam logic [6:0] TRIG64_56 = 7'd56;

    localparam int CTI_CHARS     = 4;
    localparam int TICKS_PER_BIT = 16;

    typedef enum logic {THI_IDLE, THI_PEND} thi_state_t;

endpackage

// File: rtl/uart_cti_timer.sv
// uart_cti_timer: character-timeout counter and CTI flag
module uart_cti_timer
    import uart_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       BAUDCE,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       clear,
    input  logic       nonempty,
    output logic       CTI
);

    logic [3:0]       bits;
    logic [CNT_W-1:0] timeout;
    logic [CNT_W-1:0] cnt;

    // frame length (start + data + parity + stop) scaled to four characters of 16x ticks
    always_comb begin
        bits    = 4'd7 + {2'b00, WLS} + {3'b000, PEN} + {3'b000, STB};
        timeout = CNT_W'(bits) * CNT_W'(CTI_CHARS * TICKS_PER_BIT);
    end

    // saturating tick counter; CTI latches once the count reaches the current timeout
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt <= '0;
            CTI <= 1'b0;
        end else begin
            cnt <= clear ? '0 : (BAUDCE && cnt < timeout) ? cnt + 1'b1 : cnt;
            CTI <= clear ? 1'b0 : (nonempty && cnt >= timeout) ? 1'b1 : CTI;
        end
    end

endmodule

// File: rtl/uart_int_source.sv
// uart_int_source: RDA, CTI and THI interrupt-source flags for the 16750 prioritiser
module uart_int_source
    import uart_pkg::*;
#(
    parameter int CNT_W           = 10,
    parameter int FIFO_DEPTH_LOG2 = 6
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     BAUDCE,
    input  logic [1:0]               WLS,
    input  logic                     STB,
    input  logic                     PEN,
    input  logic                     FIFOEN,
    input  logic                     FIFO64,
    input  logic [1:0]               RXTRIG,
    input  logic [FIFO_DEPTH_LOG2:0] RXCOUNT,
    input  logic                     RXACT,
    input  logic                     RBR_RD,
    input  logic                     THR_WR,
    input  logic                     TXEMPTY,
    input  logic                     ETBEI,
    input  logic                     IIR_RD,
    input  logic                     IIR_THI,
    output logic                     RDA,
    output logic                     CTI,
    output logic                     THI
);

    logic [FIFO_DEPTH_LOG2:0] level;
    logic                     rda_d;
    logic                     clear;
    logic                     nonempty;
    logic                     txempty_q;
    logic                     etbei_q;
    logic                     thi_set;
    logic                     thi_clr;
    thi_state_t               state;
    thi_state_t               state_next;

    // trigger level selection and receive-side conditions
    always_comb begin
        level = FIFO64 ? (RXTRIG == 2'b00 ? TRIG64_1 : RXTRIG == 2'b01 ? TRIG64_16 :
                          RXTRIG == 2'b10 ? TRIG64_32 : TRIG64_56)
                       : (RXTRIG == 2'b00 ? TRIG16_1 : RXTRIG == 2'b01 ? TRIG16_4 :
                          RXTRIG == 2'b10 ? TRIG16_8 : TRIG16_14);
        nonempty = RXCOUNT != '0;
        rda_d    = FIFOEN ? RXCOUNT >= level : nonempty;
        clear    = RXACT | RBR_RD | ~nonempty | ~FIFOEN;
    end

    // RDA register and edge-detect history for the THR-empty sources
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            RDA       <= 1'b0;
            txempty_q <= 1'b1;
            etbei_q   <= 1'b0;
        end else begin
            RDA       <= rda_d;
            txempty_q <= TXEMPTY;
            etbei_q   <= ETBEI;
        end
    end

    // THI state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= THI_IDLE;
        else       state <= state_next;
    end

    // THI next state: clear beats a simultaneous set
    always_comb begin
        thi_set    = (TXEMPTY & ~txempty_q) | (ETBEI & ~etbei_q & TXEMPTY);
        thi_clr    = THR_WR | (IIR_RD & IIR_THI);
        state_next = thi_clr ? THI_IDLE : (thi_set ? THI_PEND : state);
    end

    assign THI = state == THI_PEND;

    uart_cti_timer #(.CNT_W(CNT_W)) u_cti (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .BAUDCE   (BAUDCE),
        .WLS      (WLS),
        .STB      (STB),
        .PEN      (PEN),
        .clear    (clear),
        .nonempty (nonempty),
        .CTI      (CTI)
    );

endmodule

// File: tb/tb_uart_int_source.sv
// tb_uart_int_source: directed and randomized checks of uart_int_source against a behavioural model
module tb_uart_int_source;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b1;
    logic       BAUDCE, STB, PEN, FIFOEN, FIFO64, RXACT, RBR_RD, THR_WR;
    logic       TXEMPTY, ETBEI, IIR_RD, IIR_THI;
    logic [1:0] WLS, RXTRIG;
    logic [6:0] RXCOUNT;
    logic       RDA, CTI, THI;

    int checks = 0;
    int errors = 0;

    int m_cnt;
    bit m_cti, m_thi, m_rda, m_txe_h, m_etb_h;
    int lv16[4] = '{1, 4, 8, 14};
    int lv64[4] = '{1, 16, 32, 56};

    uart_int_source dut (
        .CLK(CLK), .RSTN(RSTN), .BAUDCE(BAUDCE), .WLS(WLS), .STB(STB), .PEN(PEN),
        .FIFOEN(FIFOEN), .FIFO64(FIFO64), .RXTRIG(RXTRIG), .RXCOUNT(RXCOUNT),
        .RXACT(RXACT), .RBR_RD(RBR_RD), .THR_WR(THR_WR), .TXEMPTY(TXEMPTY),
        .ETBEI(ETBEI), .IIR_RD(IIR_RD), .IIR_THI(IIR_THI),
        .RDA(RDA), .CTI(CTI), .THI(THI)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_cti = 0; m_thi = 0; m_rda = 0; m_txe_h = 1; m_etb_h = 0;
    endtask

    // one clock of the spec rules, using the inputs as they stand before the edge
    task automatic model_step();
        int to, lvl;
        bit clr, tset, tclr;
        lvl   = FIFO64 ? lv64[RXTRIG] : lv16[RXTRIG];
        to    = (7 + WLS + PEN + STB) * 64;
        clr   = RXACT || RBR_RD || RXCOUNT == 0 || !FIFOEN;
        m_rda = FIFOEN ? (RXCOUNT >= lvl) : (RXCOUNT != 0);
        m_cti = clr ? 1'b0 : (m_cnt >= to) ? 1'b1 : m_cti;
        m_cnt = clr ? 0 : (BAUDCE && m_cnt < to) ? m_cnt + 1 : m_cnt;
        tset  = (TXEMPTY && !m_txe_h) || (ETBEI && !m_etb_h && TXEMPTY);
        tclr  = THR_WR || (IIR_RD && IIR_THI);
        m_thi = tclr ? 1'b0 : tset ? 1'b1 : m_thi;
        m_txe_h = TXEMPTY;
        m_etb_h = ETBEI;
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        chk({tag, ".RDA"}, RDA, m_rda);
        chk({tag, ".CTI"}, CTI, m_cti);
        chk({tag, ".THI"}, THI, m_thi);
    endtask

    task automatic tick4(input int n);
        repeat (n) begin
            BAUDCE = 1'b1; cyc("t4");
            BAUDCE = 1'b0; repeat (3) cyc("t4");
        end
    endtask

    initial begin
        BAUDCE = 0; STB = 0; PEN = 0; FIFOEN = 0; FIFO64 = 0; RXACT = 0; RBR_RD = 0;
        THR_WR = 0; TXEMPTY = 0; ETBEI = 0; IIR_RD = 0; IIR_THI = 0;
        WLS = 2'b00; RXTRIG = 2'b00; RXCOUNT = 7'd0;
        #2 RSTN = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_rda", RDA, 1'b0);
        chk("reset_cti", CTI, 1'b0);
        chk("reset_thi", THI, 1'b0);
        #3 RSTN = 1'b1;

        // RDA trigger levels
        FIFOEN = 1; FIFO64 = 0; RXTRIG = 2'b10; RXCOUNT = 7;
        cyc("rda16"); chk("rda16_7", RDA, 1'b0);
        RXCOUNT = 8;  cyc("rda16"); chk("rda16_8", RDA, 1'b1);
        RXCOUNT = 7;  cyc("rda16"); chk("rda16_7b", RDA, 1'b0);
        FIFO64 = 1; RXTRIG = 2'b11; RXCOUNT = 55;
        cyc("rda64"); chk("rda64_55", RDA, 1'b0);
        RXCOUNT = 56; cyc("rda64"); chk("rda64_56", RDA, 1'b1);
        RXCOUNT = 64; cyc("rda64"); chk("rda64_64", RDA, 1'b1);
        FIFOEN = 0; RXCOUNT = 1; cyc("rda_nofifo"); chk("rda_nofifo_1", RDA, 1'b1);
        RXCOUNT = 0; cyc("rda_nofifo"); chk("rda_nofifo_0", RDA, 1'b0);

        // CTI with 8N1: 640 ticks
        FIFOEN = 1; FIFO64 = 0; RXTRIG = 2'b00; WLS = 2'b11; PEN = 0; STB = 0; RXCOUNT = 3;
        RBR_RD = 1; cyc("cti10"); RBR_RD = 0;
        BAUDCE = 1;
        repeat (640) cyc("cti10");
        chk("cti_at_640", CTI, 1'b0);
        cyc("cti10"); chk("cti_after_640", CTI, 1'b1);
        RBR_RD = 1; cyc("cti10"); RBR_RD = 0; chk("cti_rbr_clear", CTI, 1'b0);
        repeat (638) cyc("cti10");
        RXACT = 1; cyc("cti10"); RXACT = 0;
        repeat (5) cyc("cti10");
        chk("cti_rxact_639", CTI, 1'b0);
        RXACT = 1; RBR_RD = 1; cyc("cti_both"); RXACT = 0; RBR_RD = 0;

        // CTI with slow ticks: 8-bit frame gives 512
        WLS = 2'b00; PEN = 1; STB = 0; BAUDCE = 0;
        RBR_RD = 1; cyc("cti8"); RBR_RD = 0;
        tick4(511);
        BAUDCE = 1; cyc("cti8"); BAUDCE = 0;
        chk("cti_tick512", CTI, 1'b0);
        cyc("cti8"); chk("cti_tick512_next", CTI, 1'b1);
        RBR_RD = 1; cyc("cti_lcr"); RBR_RD = 0;
        tick4(300);
        WLS = 2'b11;
        tick4(300);
        chk("cti_lcr_extended", CTI, 1'b0);
        tick4(110);
        chk("cti_lcr_reached", CTI, 1'b1);
        RBR_RD = 1; cyc("cti_lcr"); RBR_RD = 0;
        tick4(600);
        WLS = 2'b00;
        cyc("cti_shrink"); cyc("cti_shrink");
        chk("cti_shrink_set", CTI, 1'b1);
        FIFOEN = 0; cyc("cti_off"); chk("cti_fifo_off", CTI, 1'b0);
        FIFOEN = 1;

        // THI
        TXEMPTY = 0; ETBEI = 0; cyc("thi");
        TXEMPTY = 1; cyc("thi"); chk("thi_txe_rise", THI, 1'b1);
        IIR_RD = 1; IIR_THI = 0; cyc("thi"); chk("thi_iir_other", THI, 1'b1);
        IIR_THI = 1; cyc("thi"); chk("thi_iir_read", THI, 1'b0);
        IIR_RD = 0; IIR_THI = 0;
        TXEMPTY = 0; cyc("thi");
        TXEMPTY = 1; THR_WR = 1; cyc("thi"); chk("thi_clear_wins", THI, 1'b0);
        THR_WR = 0; cyc("thi"); chk("thi_stays_low", THI, 1'b0);
        ETBEI = 1; cyc("thi"); chk("thi_etbei_rise", THI, 1'b1);
        THR_WR = 1; cyc("thi"); chk("thi_thr_wr", THI, 1'b0);
        THR_WR = 0;

        // randomized segments
        for (int s = 0; s < 6; s++) begin
            WLS = 2'($urandom_range(0, 3)); PEN = 1'($urandom_range(0, 1));
            STB = 1'($urandom_range(0, 1)); FIFO64 = 1'($urandom_range(0, 1));
            RXTRIG = 2'($urandom_range(0, 3)); FIFOEN = ($urandom_range(0, 7) != 0);
            RXCOUNT = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 64));
            for (int i = 0; i < 1500; i++) begin
                BAUDCE  = 1'($urandom_range(0, 1));
                RXACT   = ($urandom_range(0, 999) == 0);
                RBR_RD  = ($urandom_range(0, 999) == 0);
                THR_WR  = ($urandom_range(0, 49) == 0);
                IIR_RD  = ($urandom_range(0, 29) == 0);
                IIR_THI = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 39) == 0) TXEMPTY = ~TXEMPTY;
                if ($urandom_range(0, 59) == 0) ETBEI = ~ETBEI;
                if ($urandom_range(0, 599) == 0) WLS = 2'($urandom_range(0, 3));
                if ((RXACT || RBR_RD) && $urandom_range(0, 1) == 1) RXCOUNT = 7'($urandom_range(0, 64));
                cyc("rnd");
            end
        end
        RXACT = 0; RBR_RD = 0; THR_WR = 0; IIR_RD = 0; IIR_THI = 0;

        // asynchronous reset with CTI and THI both pending
        FIFOEN = 1; RXCOUNT = 3; WLS = 2'b00; PEN = 0; STB = 0; ETBEI = 0; TXEMPTY = 0;
        RBR_RD = 1; cyc("prerst"); RBR_RD = 0;
        BAUDCE = 1;
        repeat (450) cyc("prerst");
        TXEMPTY = 1; cyc("prerst");
        chk("prerst_cti", CTI, 1'b1);
        chk("prerst_thi", THI, 1'b1);
        #3 RSTN = 1'b0;
        #1;
        chk("async_rst_rda", RDA, 1'b0);
        chk("async_rst_cti", CTI, 1'b0);
        chk("async_rst_thi", THI, 1'b0);
        model_reset();
        repeat (2) @(posedge CLK);
        #2 RSTN = 1'b1;
        BAUDCE = 0;
        repeat (3) cyc("postrst");
        chk("postrst_no_thi", THI, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
